// File: rtl/motor_drive_control.sv
// motor_drive_control
//   Drives the left/right motor H-bridges from the 4-bit direction command of
//   the line-sensor stage.  Provides a soft-start duty ramp, timed in-place
//   pivots for ninety-degree turns, and an immediate stop.
//
//   Ports
//     clk           system clock (50 MHz)
//     rst_n         asynchronous active-low reset
//     DIR[3:0]      command: [3:2] 00 proceed / 01 left / 10 right / 11 stop,
//                            [1:0] 01 veer / 10 hard / 11 ninety
//     enable        master run enable, low behaves as STOP
//     pwm_l/pwm_r   motor PWM outputs
//     dir_l/dir_r   motor direction, 1 = forward
//     brake         high while stopped
//     pivot_active  high while pivoting
//     duty_l/duty_r current duty values
//
//   state   | meaning
//   --------+--------------------------------------------------------------
//   STOPPED | brake on, duties held at 0, both wheels forward
//   RUN     | brake off, duties ramp toward the decoded targets
//   PIVOT   | timed in-place turn, inner wheel reversed, both at PIVOT_DUTY
module motor_drive_control #(
    parameter int PWM_BITS     = 8,
    parameter int FULL_DUTY    = 200,
    parameter int VEER_DUTY    = 120,
    parameter int PIVOT_DUTY   = 160,
    parameter int RAMP_STEP    = 4,
    parameter int RAMP_DIV     = 50_000,
    parameter int PIVOT_CYCLES = 25_000_000
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic [3:0]          DIR,
    input  logic                enable,
    output logic                pwm_l,
    output logic                pwm_r,
    output logic                dir_l,
    output logic                dir_r,
    output logic                brake,
    output logic                pivot_active,
    output logic [PWM_BITS-1:0] duty_l,
    output logic [PWM_BITS-1:0] duty_r
);

    localparam int PRE_W = (RAMP_DIV > 1) ? $clog2(RAMP_DIV) : 1;
    localparam int TMR_W = (PIVOT_CYCLES > 1) ? $clog2(PIVOT_CYCLES) : 1;

    localparam logic [PRE_W-1:0]    PRE_LAST = PRE_W'(RAMP_DIV - 1);
    localparam logic [TMR_W-1:0]    TMR_LAST = TMR_W'(PIVOT_CYCLES - 1);
    localparam logic [PWM_BITS-1:0] D_FULL   = PWM_BITS'(FULL_DUTY);
    localparam logic [PWM_BITS-1:0] D_VEER   = PWM_BITS'(VEER_DUTY);
    localparam logic [PWM_BITS-1:0] D_PIVOT  = PWM_BITS'(PIVOT_DUTY);
    localparam logic [PWM_BITS-1:0] D_STEP   = PWM_BITS'(RAMP_STEP);

    localparam logic [1:0] ST_STOPPED = 2'd0;
    localparam logic [1:0] ST_RUN     = 2'd1;
    localparam logic [1:0] ST_PIVOT   = 2'd2;

    // Input capture
    logic [3:0]          dir_q;
    logic                en_q;

    // Control state
    logic [1:0]          state_q, state_d;
    logic                armed_q, armed_d;
    logic                side_q, side_d;        // 1 = pivoting right
    logic [TMR_W-1:0]    tmr_q, tmr_d;
    logic [PRE_W-1:0]    pre_q, pre_d;
    logic [PWM_BITS-1:0] drv_l_q, drv_l_d;      // last drive-code targets
    logic [PWM_BITS-1:0] drv_r_q, drv_r_d;

    // Datapath
    logic [PWM_BITS-1:0] duty_l_q, duty_l_d;
    logic [PWM_BITS-1:0] duty_r_q, duty_r_d;
    logic                dir_l_q, dir_l_d;
    logic                dir_r_q, dir_r_d;
    logic [PWM_BITS-1:0] pwm_cnt_q;
    logic                pwm_l_q, pwm_r_q;

    // Decode
    logic                cmd_drive, cmd_nl, cmd_nr, cmd_ninety, halt;
    logic [PWM_BITS-1:0] dec_l, dec_r;
    logic [PWM_BITS-1:0] tgt_l, tgt_r;
    logic                ramp_tick;
    logic                force0;

    // Never overshoots the target and never wraps: the step is clipped to the
    // remaining gap, and a lowered target is taken at once.
    function automatic logic [PWM_BITS-1:0] ramp_next(
        input logic [PWM_BITS-1:0] cur,
        input logic [PWM_BITS-1:0] tgt,
        input logic                tick,
        input logic                zero
    );
        logic [PWM_BITS-1:0] gap;
        logic [PWM_BITS-1:0] res;
        gap = tgt - cur;
        res = cur;
        if (zero) begin
            res = '0;
        end else if (cur > tgt) begin
            res = tgt;
        end else if (tick && (cur < tgt)) begin
            res = (gap < D_STEP) ? tgt : cur + D_STEP;
        end
        return res;
    endfunction

    always_comb begin
        cmd_drive = 1'b0;
        cmd_nl    = 1'b0;
        cmd_nr    = 1'b0;
        dec_l     = '0;
        dec_r     = '0;
        case (dir_q)
            4'b0000: begin cmd_drive = 1'b1; dec_l = D_FULL; dec_r = D_FULL; end
            4'b0101: begin cmd_drive = 1'b1; dec_l = D_VEER; dec_r = D_FULL; end
            4'b0110: begin cmd_drive = 1'b1; dec_l = '0;     dec_r = D_FULL; end
            4'b1001: begin cmd_drive = 1'b1; dec_l = D_FULL; dec_r = D_VEER; end
            4'b1010: begin cmd_drive = 1'b1; dec_l = D_FULL; dec_r = '0;     end
            4'b0111: cmd_nl = 1'b1;
            4'b1011: cmd_nr = 1'b1;
            default: ;
        endcase
    end

    assign cmd_ninety = cmd_nl | cmd_nr;
    // Anything that is neither a drive nor a ninety code counts as STOP.
    assign halt       = !en_q || !(cmd_drive || cmd_ninety);
    assign ramp_tick  = (pre_q == PRE_LAST);
    assign pre_d      = ramp_tick ? '0 : pre_q + PRE_W'(1);
    assign drv_l_d    = cmd_drive ? dec_l : drv_l_q;
    assign drv_r_d    = cmd_drive ? dec_r : drv_r_q;

    always_comb begin
        state_d = state_q;
        side_d  = side_q;
        case (state_q)
            ST_STOPPED: begin
                if (!halt && cmd_drive) begin
                    state_d = ST_RUN;
                end else if (!halt && cmd_ninety && armed_q) begin
                    state_d = ST_PIVOT;
                    side_d  = cmd_nr;
                end
            end
            ST_RUN: begin
                if (halt) begin
                    state_d = ST_STOPPED;
                end else if (cmd_ninety && armed_q) begin
                    state_d = ST_PIVOT;
                    side_d  = cmd_nr;
                end
            end
            ST_PIVOT: begin
                if (halt) begin
                    state_d = ST_STOPPED;
                end else if (tmr_q == TMR_LAST) begin
                    state_d = ST_RUN;
                end
            end
            default: state_d = ST_STOPPED;
        endcase
    end

    // Every edge that enters or leaves a pivot, or stops, zeroes both duties;
    // these are the only edges on which a direction bit may change.
    always_comb begin
        force0 = (state_d == ST_STOPPED)
              || ((state_d == ST_PIVOT) && (state_q != ST_PIVOT))
              || ((state_d == ST_RUN) && (state_q == ST_PIVOT));

        tgt_l   = '0;
        tgt_r   = '0;
        dir_l_d = 1'b1;
        dir_r_d = 1'b1;
        case (state_d)
            ST_RUN: begin
                // A held ninety code that can no longer pivot keeps the last
                // drive targets.
                tgt_l = cmd_drive ? dec_l : drv_l_q;
                tgt_r = cmd_drive ? dec_r : drv_r_q;
            end
            ST_PIVOT: begin
                tgt_l   = D_PIVOT;
                tgt_r   = D_PIVOT;
                dir_l_d = side_d;
                dir_r_d = !side_d;
            end
            default: ;
        endcase

        duty_l_d = ramp_next(duty_l_q, tgt_l, ramp_tick, force0);
        duty_r_d = ramp_next(duty_r_q, tgt_r, ramp_tick, force0);

        tmr_d = '0;
        if ((state_q == ST_PIVOT) && (state_d == ST_PIVOT)) begin
            tmr_d = tmr_q + TMR_W'(1);
        end

        armed_d = armed_q;
        if ((state_d == ST_PIVOT) && (state_q != ST_PIVOT)) begin
            armed_d = 1'b0;
        end else if (!cmd_ninety) begin
            armed_d = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            dir_q     <= 4'b0000;
            en_q      <= 1'b0;
            state_q   <= ST_STOPPED;
            armed_q   <= 1'b1;
            side_q    <= 1'b0;
            tmr_q     <= '0;
            pre_q     <= '0;
            drv_l_q   <= D_FULL;
            drv_r_q   <= D_FULL;
            duty_l_q  <= '0;
            duty_r_q  <= '0;
            dir_l_q   <= 1'b1;
            dir_r_q   <= 1'b1;
            pwm_cnt_q <= '0;
            pwm_l_q   <= 1'b0;
            pwm_r_q   <= 1'b0;
        end else begin
            dir_q     <= DIR;
            en_q      <= enable;
            state_q   <= state_d;
            armed_q   <= armed_d;
            side_q    <= side_d;
            tmr_q     <= tmr_d;
            pre_q     <= pre_d;
            drv_l_q   <= drv_l_d;
            drv_r_q   <= drv_r_d;
            duty_l_q  <= duty_l_d;
            duty_r_q  <= duty_r_d;
            dir_l_q   <= dir_l_d;
            dir_r_q   <= dir_r_d;
            pwm_cnt_q <= pwm_cnt_q + PWM_BITS'(1);
            pwm_l_q   <= (pwm_cnt_q < duty_l_q);
            pwm_r_q   <= (pwm_cnt_q < duty_r_q);
        end
    end

    assign pwm_l        = pwm_l_q;
    assign pwm_r        = pwm_r_q;
    assign dir_l        = dir_l_q;
    assign dir_r        = dir_r_q;
    assign duty_l       = duty_l_q;
    assign duty_r       = duty_r_q;
    assign brake        = (state_q == ST_STOPPED);
    assign pivot_active = (state_q == ST_PIVOT);

endmodule

// File: tb/tb_motor_drive_control.sv
module tb_motor_drive_control;

    localparam int PWM_BITS = 8;

    logic                clk = 1'b0;
    logic                rst_n = 1'b0;
    logic [3:0]          dir_cmd = 4'b0000;
    logic                enable = 1'b0;
    logic                pwm_l, pwm_r, dir_l, dir_r, brake, pivot_active;
    logic [PWM_BITS-1:0] duty_l, duty_r;

    int n_checks = 0;
    int n_fail   = 0;

    motor_drive_control #(
        .PWM_BITS    (PWM_BITS),
        .FULL_DUTY   (200),
        .VEER_DUTY   (120),
        .PIVOT_DUTY  (160),
        .RAMP_STEP   (4),
        .RAMP_DIV    (4),
        .PIVOT_CYCLES(100)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .DIR         (dir_cmd),
        .enable      (enable),
        .pwm_l       (pwm_l),
        .pwm_r       (pwm_r),
        .dir_l       (dir_l),
        .dir_r       (dir_r),
        .brake       (brake),
        .pivot_active(pivot_active),
        .duty_l      (duty_l),
        .duty_r      (duty_r)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input int obs, input int exp);
        n_checks++;
        if (obs != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic wait_duty_l_ge(input int lvl, input int budget, input string tag);
        int k;
        k = 0;
        while (int'(duty_l) < lvl && k < budget) begin
            step(1);
            k++;
        end
        check_eq(tag, (int'(duty_l) >= lvl) ? 1 : 0, 1);
    endtask

    initial begin
        int k, hi_l, hi_r, cnt, first_dl, first_dr, first_duty, last_duty, last_eq, done;

        // Reset values
        step(2);
        check_eq("rst_pwm_l", pwm_l, 0);
        check_eq("rst_pwm_r", pwm_r, 0);
        check_eq("rst_dir_l", dir_l, 1);
        check_eq("rst_dir_r", dir_r, 1);
        check_eq("rst_brake", brake, 1);
        check_eq("rst_pivot", pivot_active, 0);
        check_eq("rst_duty_l", duty_l, 0);
        check_eq("rst_duty_r", duty_r, 0);

        // Soft start to FULL: +4 every 4 clocks
        rst_n = 1'b1;
        step(2);
        dir_cmd = 4'b0000;
        enable  = 1'b1;
        k = 0;
        while (duty_l == 0 && k < 40) begin
            step(1);
            k++;
        end
        check_eq("ramp_first_l", duty_l, 4);
        check_eq("ramp_first_r", duty_r, 4);
        check_eq("ramp_brake", brake, 0);
        step(3);
        check_eq("ramp_hold", duty_l, 4);
        step(1);
        check_eq("ramp_second", duty_l, 8);
        for (int s = 3; s <= 50; s++) begin
            step(4);
            check_eq("ramp_step", duty_l, 4 * s);
        end
        step(8);
        check_eq("ramp_top_l", duty_l, 200);
        check_eq("ramp_top_r", duty_r, 200);

        hi_l = 0;
        hi_r = 0;
        for (int i = 0; i < 256; i++) begin
            step(1);
            hi_l += pwm_l;
            hi_r += pwm_r;
        end
        check_eq("pwm_high_l", hi_l, 200);
        check_eq("pwm_high_r", hi_r, 200);

        // Veer left: inner wheel drops on the state edge
        dir_cmd = 4'b0101;
        step(2);
        check_eq("veer_l", duty_l, 120);
        check_eq("veer_r", duty_r, 200);

        // Hard right: right drops at once, left ramps back up
        dir_cmd = 4'b1010;
        step(2);
        check_eq("hard_r_drop", duty_r, 0);
        wait_duty_l_ge(200, 200, "hard_l_ramp_timeout");
        check_eq("hard_l_top", duty_l, 200);

        // Ninety left, held
        dir_cmd = 4'b0111;
        cnt = 0; first_dl = 9; first_dr = 9; first_duty = 999;
        last_duty = 0; last_eq = 0; done = 0;
        for (int i = 0; i < 400 && done == 0; i++) begin
            step(1);
            if (pivot_active) begin
                cnt++;
                if (cnt == 1) begin
                    first_dl   = dir_l;
                    first_dr   = dir_r;
                    first_duty = duty_l;
                end
                last_duty = duty_l;
                last_eq   = (duty_l == duty_r) ? 1 : 0;
            end else if (cnt > 0) begin
                done = 1;
            end
        end
        check_eq("pivot_end_timeout", done, 1);
        check_eq("pivot_cycles", cnt, 100);
        check_eq("pivot_dir_l", first_dl, 0);
        check_eq("pivot_dir_r", first_dr, 1);
        check_eq("pivot_entry_duty", first_duty, 0);
        check_eq("pivot_ramp_level", (last_duty == 96 || last_duty == 100) ? 1 : 0, 1);
        check_eq("pivot_ramp_equal", last_eq, 1);
        check_eq("post_pivot_duty", duty_l, 0);
        check_eq("post_pivot_dir_l", dir_l, 1);
        check_eq("post_pivot_dir_r", dir_r, 1);
        check_eq("post_pivot_brake", brake, 0);

        cnt = 0;
        for (int i = 0; i < 300; i++) begin
            step(1);
            cnt += pivot_active;
        end
        check_eq("no_retrigger", cnt, 0);
        check_eq("held_l", duty_l, 200);
        check_eq("held_r", duty_r, 0);

        // Re-arm, pivot again, stop mid-pivot
        dir_cmd = 4'b0000;
        step(10);
        dir_cmd = 4'b0111;
        k = 0;
        while (!pivot_active && k < 10) begin
            step(1);
            k++;
        end
        check_eq("pivot2_start", pivot_active, 1);
        step(20);
        dir_cmd = 4'b1111;
        step(2);
        check_eq("stop_brake", brake, 1);
        check_eq("stop_pivot", pivot_active, 0);
        check_eq("stop_duty_l", duty_l, 0);
        check_eq("stop_duty_r", duty_r, 0);
        check_eq("stop_dir_l", dir_l, 1);
        check_eq("stop_dir_r", dir_r, 1);
        step(1);
        check_eq("stop_pwm", {pwm_l, pwm_r}, 0);

        // Enable dropped while ramping
        dir_cmd = 4'b0000;
        wait_duty_l_ge(8, 100, "en_ramp_timeout");
        check_eq("en_ramping", (duty_l < 200) ? 1 : 0, 1);
        enable = 1'b0;
        step(2);
        check_eq("en_low_duty_l", duty_l, 0);
        check_eq("en_low_duty_r", duty_r, 0);
        check_eq("en_low_brake", brake, 1);

        // Unknown code stops
        enable = 1'b1;
        wait_duty_l_ge(4, 50, "code_ramp_timeout");
        dir_cmd = 4'b1100;
        step(2);
        check_eq("code1100_brake", brake, 1);
        check_eq("code1100_duty", duty_l, 0);

        // Asynchronous reset between clock edges
        dir_cmd = 4'b0000;
        wait_duty_l_ge(20, 200, "async_ramp_timeout");
        #2 rst_n = 1'b0;
        #1;
        check_eq("arst_duty_l", duty_l, 0);
        check_eq("arst_duty_r", duty_r, 0);
        check_eq("arst_brake", brake, 1);
        check_eq("arst_pwm", {pwm_l, pwm_r}, 0);
        check_eq("arst_dirs", {dir_l, dir_r}, 3);
        check_eq("arst_pivot", pivot_active, 0);
        step(1);
        rst_n = 1'b1;
        step(1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
